// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state type, default sizing and address-split helpers for dmem_cache
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, MISS, WWAIT} dmem_state_t;
  localparam int unsigned DEF_LINES = 16;
  localparam int unsigned DEF_MEM_WORDS = 1024;
  localparam int unsigned DEF_MISS_LAT = 4;
  localparam int unsigned DEF_WR_LAT = 3;
  function automatic int unsigned word_of(input logic [31:0] a, input int unsigned words);
    return (a >> 2) & (words - 1);
  endfunction
  function automatic int unsigned line_of(input logic [31:0] a, input int unsigned lines, input int unsigned words);
    return word_of(a, words) & (lines - 1);
  endfunction
  function automatic int unsigned tag_of(input logic [31:0] a, input int unsigned lines, input int unsigned words);
    return word_of(a, words) / lines;
  endfunction
endpackage

// File: rtl/dmem_wbuf.sv
// dmem_wbuf: single-entry write buffer that holds a store for WR_LAT cycles, then writes backing memory
module dmem_wbuf #(
  parameter int unsigned AW = 10,
  parameter int unsigned WR_LAT = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   data_i,
  output logic          busy_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [31:0]   mem_data_o
);
  localparam int CW = $clog2(WR_LAT + 1);
  logic [CW-1:0] left_q;
  logic [AW-1:0] addr_q;
  logic [31:0] data_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      left_q <= '0;
    end else if (load_i) begin
      left_q <= CW'(WR_LAT);
      addr_q <= addr_i;
      data_q <= data_i;
    end else if (busy_o) begin
      left_q <= left_q - 1'b1;
    end
  end
  assign busy_o = left_q != '0;
  assign mem_we_o = !rst && left_q == CW'(1);
  assign mem_addr_o = addr_q;
  assign mem_data_o = data_q;
endmodule

// File: rtl/dmem_cache.sv
// dmem_cache: direct-mapped write-through, no-write-allocate data cache over a fixed-latency word memory
module dmem_cache import dmem_pkg::*; #(
  parameter int unsigned LINES = DEF_LINES,
  parameter int unsigned MEM_WORDS = DEF_MEM_WORDS,
  parameter int unsigned MISS_LAT = DEF_MISS_LAT,
  parameter int unsigned WR_LAT = DEF_WR_LAT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_pulse,
  input  logic        rw,
  input  logic [31:0] addr,
  input  logic [31:0] data_write,
  output logic [31:0] data_read,
  output logic        dack
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int IW = LINES > 1 ? $clog2(LINES) : 1;
  localparam int TW = MEM_WORDS > LINES ? AW - $clog2(LINES) : 1;
  localparam int MW = $clog2(MISS_LAT + 1);
  dmem_state_t state_q, state_d;
  logic [MW-1:0] miss_cnt_q, miss_cnt_d;
  logic [LINES-1:0] valid_q;
  logic [TW-1:0] tag_q [LINES];
  logic [31:0] line_q [LINES];
  logic [31:0] mem_q [MEM_WORDS];
  logic [AW-1:0] w, mem_wa;
  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  logic [31:0] mem_wd;
  logic hit, busy, mem_we, wb_load, idle_ack, miss_ack, ww_ack;
  assign w = AW'(word_of(addr, MEM_WORDS));
  assign idx = IW'(line_of(addr, LINES, MEM_WORDS));
  assign tag = TW'(tag_of(addr, LINES, MEM_WORDS));
  assign hit = valid_q[idx] && tag_q[idx] == tag;
  assign idle_ack = state_q == IDLE && req_pulse && (rw ? hit : !busy);
  // a pending store drains before the miss latency starts counting
  assign miss_ack = state_q == MISS && !busy && miss_cnt_q == MW'(MISS_LAT - 1);
  assign ww_ack = state_q == WWAIT && !busy;
  assign dack = !rst && (idle_ack || miss_ack || ww_ack);
  assign wb_load = dack && !rw;
  assign data_read = (dack && rw) ? (state_q == IDLE ? line_q[idx] : mem_q[w]) : '0;
  always_comb begin
    state_d = (state_q == IDLE && req_pulse && !idle_ack) ? (rw ? MISS : WWAIT) :
              (miss_ack || ww_ack) ? IDLE : state_q;
    miss_cnt_d = (state_q != MISS || miss_ack) ? '0 : miss_cnt_q + MW'(!busy);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      miss_cnt_q <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      miss_cnt_q <= miss_cnt_d;
      if (miss_ack) begin
        valid_q[idx] <= 1'b1;
        tag_q[idx] <= tag;
        line_q[idx] <= mem_q[w];
      end
      if (wb_load && hit) line_q[idx] <= data_write;
    end
  end
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_wa] <= mem_wd;
  end
  dmem_wbuf #(.AW(AW), .WR_LAT(WR_LAT)) u_wbuf (
    .clk(clk),
    .rst(rst),
    .load_i(wb_load),
    .addr_i(w),
    .data_i(data_write),
    .busy_o(busy),
    .mem_we_o(mem_we),
    .mem_addr_o(mem_wa),
    .mem_data_o(mem_wd)
  );
endmodule

// File: tb/tb_dmem_cache.sv
// tb_dmem_cache: directed-vector bench for dmem_cache latencies, data and reset behaviour
module tb_dmem_cache;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_pulse = 1'b0;
  logic rw = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] data_write = '0;
  logic [31:0] data_read;
  logic dack;
  int n_cmp = 0;
  int n_err = 0;
  int lat;
  logic [31:0] rd;
  dmem_cache dut (
    .clk(clk),
    .rst(rst),
    .req_pulse(req_pulse),
    .rw(rw),
    .addr(addr),
    .data_write(data_write),
    .data_read(data_read),
    .dack(dack)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  // issue one request, return cycles until dack (-1 on timeout) and the data seen with it
  task automatic req(input logic r, input logic [31:0] a, input logic [31:0] d, output int l, output logic [31:0] q);
    rw = r;
    addr = a;
    data_write = d;
    req_pulse = 1'b1;
    l = -1;
    q = 'x;
    for (int c = 0; c < 40 && l < 0; c++) begin
      #4;
      if (dack) begin
        l = c;
        q = data_read;
      end
      @(posedge clk);
      #1;
      req_pulse = 1'b0;
    end
  endtask
  initial begin
    @(posedge clk);
    #1;
    #4;
    chk("rst_dack", 32'(dack), 32'd0);
    chk("rst_data", data_read, 32'd0);
    step(1);
    rst = 1'b0;
    req(1'b0, 32'h40, 32'hDEADBEEF, lat, rd);
    chk("preload_wr_lat", 32'(lat), 32'd0);
    step(4);
    chk("preload_mem", dut.mem_q[16], 32'hDEADBEEF);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    req(1'b1, 32'h40, 32'h0, lat, rd);
    chk("cold_rd_lat", 32'(lat), 32'd4);
    chk("cold_rd_data", rd, 32'hDEADBEEF);
    req(1'b1, 32'h40, 32'h0, lat, rd);
    chk("hit_rd_lat", 32'(lat), 32'd0);
    chk("hit_rd_data", rd, 32'hDEADBEEF);
    req(1'b0, 32'h40, 32'h12345678, lat, rd);
    chk("hit_wr_lat", 32'(lat), 32'd0);
    req(1'b1, 32'h40, 32'h0, lat, rd);
    chk("rd_after_wr_lat", 32'(lat), 32'd0);
    chk("rd_after_wr_data", rd, 32'h12345678);
    chk("mem_before_drain", dut.mem_q[16], 32'hDEADBEEF);
    step(2);
    chk("mem_after_drain", dut.mem_q[16], 32'h12345678);
    req(1'b0, 32'h100, 32'hAAAA0001, lat, rd);
    chk("b2b_wr1_lat", 32'(lat), 32'd0);
    req(1'b0, 32'h104, 32'hBBBB0002, lat, rd);
    chk("b2b_wr2_lat", 32'(lat), 32'd3);
    step(3);
    chk("b2b_mem1", dut.mem_q[16'h40], 32'hAAAA0001);
    chk("b2b_mem2", dut.mem_q[16'h41], 32'hBBBB0002);
    req(1'b0, 32'h80, 32'hCAFE0080, lat, rd);
    chk("wr_miss_lat", 32'(lat), 32'd0);
    req(1'b1, 32'h80, 32'h0, lat, rd);
    chk("drain_rd_lat", 32'(lat), 32'd6);
    chk("drain_rd_data", rd, 32'hCAFE0080);
    req(1'b1, 32'h80, 32'h0, lat, rd);
    chk("fill_hit_lat", 32'(lat), 32'd0);
    req(1'b0, 32'h0, 32'h00001111, lat, rd);
    chk("wr0_lat", 32'(lat), 32'd0);
    step(3);
    req(1'b1, 32'h0, 32'h0, lat, rd);
    chk("conf_rd0_lat", 32'(lat), 32'd4);
    chk("conf_rd0_data", rd, 32'h00001111);
    req(1'b1, 32'h40, 32'h0, lat, rd);
    chk("conf_rd40_lat", 32'(lat), 32'd4);
    chk("conf_rd40_data", rd, 32'h12345678);
    req(1'b1, 32'h0, 32'h0, lat, rd);
    chk("conf_rd0b_lat", 32'(lat), 32'd4);
    chk("conf_rd0b_data", rd, 32'h00001111);
    rw = 1'b1;
    addr = 32'h40;
    req_pulse = 1'b1;
    #4;
    chk("mrst_c0_dack", 32'(dack), 32'd0);
    step(1);
    req_pulse = 1'b0;
    #4;
    chk("mrst_c1_dack", 32'(dack), 32'd0);
    step(1);
    rst = 1'b1;
    #4;
    chk("mrst_c2_dack", 32'(dack), 32'd0);
    chk("mrst_c2_data", data_read, 32'd0);
    step(1);
    rst = 1'b0;
    step(1);
    #4;
    chk("mrst_c4_dack", 32'(dack), 32'd0);
    step(1);
    req(1'b1, 32'h0, 32'h0, lat, rd);
    chk("post_rst_lat", 32'(lat), 32'd4);
    chk("post_rst_data", rd, 32'h00001111);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
